mem_c_stream_writer: RTL and testbench

Avalon-MM write master driving the 256-bit second port of the FPGA-side result memory (Mem C). It accepts a command (base word address, element count) and a stream of 32-bit result elements from the compute datapath. It packs eight elements per 256-bit word and issues one single-cycle write per word, so the HPS-side 128-bit port can read results after `done`.

---
 rtl/mem_c_pkg.sv | 17 +
 rtl/mem_c_lane_packer.sv | 48 ++++
 rtl/mem_c_stream_writer.sv | 143 ++++++++++++++
 tb/tb_mem_c_stream_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_c_pkg.sv
// Shared widths and FSM state type for the Mem C result-writer slice.
package mem_c_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 256;
  localparam int ELEM_W = 32;
  localparam int LEN_W  = 15;
  localparam int LANES  = DATA_W / ELEM_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } mem_c_wr_state_t;

endpackage

// File: rtl/mem_c_lane_packer.sv
// Packs ELEM_W elements into a DATA_W word, lane 0 in the low bits.
module mem_c_lane_packer #(
  parameter int DATA_W = mem_c_pkg::DATA_W,
  parameter int ELEM_W = mem_c_pkg::ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [ELEM_W-1:0] i_data,
  output logic              word_full,
  output logic [DATA_W-1:0] packed_word
);

  localparam int NLANES = DATA_W / ELEM_W;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic [LANE_W-1:0] r_lane;
  logic [DATA_W-1:0] r_acc;
  logic              w_last_lane;

  assign w_last_lane = (r_lane == LANE_W'(NLANES - 1));
  assign word_full   = i_push & w_last_lane;

  // Includes the element being pushed this cycle so a completing word can be captured directly.
  always_comb begin
    packed_word = r_acc;
    if (i_push) begin
      packed_word[int'(r_lane) * ELEM_W +: ELEM_W] = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (i_push) begin
      if (w_last_lane) begin
        r_lane <= '0;
        r_acc  <= '0;
      end else begin
        r_lane <= r_lane + LANE_W'(1);
        r_acc  <= packed_word;
      end
    end
  end

endmodule

// File: rtl/mem_c_stream_writer.sv
// Avalon-MM write master packing a 32-bit element stream into 256-bit Mem C words.
// Optional MEM_C_WRITER_PERF_EN adds a perf_cycles busy-cycle counter output.
module mem_c_stream_writer #(
  parameter int ADDR_W = mem_c_pkg::ADDR_W,
  parameter int DATA_W = mem_c_pkg::DATA_W,
  parameter int ELEM_W = mem_c_pkg::ELEM_W,
  parameter int LEN_W  = mem_c_pkg::LEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   address2,
  output logic                chipselect2,
  output logic                write2,
  output logic [DATA_W-1:0]   writedata2,
  output logic [DATA_W/8-1:0] byteenable2,
  output logic                clken2
`ifdef MEM_C_WRITER_PERF_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);

  import mem_c_pkg::*;

  mem_c_wr_state_t   r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_word_idx;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_elem_cnt;
  logic              r_wr_pend;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_run;
  logic              w_cmd_acc;
  logic              w_push;
  logic              w_last;
  logic              w_clear;
  logic              w_word_full;
  logic [DATA_W-1:0] w_packed;
  logic              w_wr;

  assign w_run     = ~reset;
  assign w_cmd_acc = (r_state == ST_IDLE) & cmd_valid;
  assign w_push    = (r_state == ST_FILL) & in_valid;
  assign w_last    = w_push & ((r_elem_cnt + LEN_W'(1)) == r_len);
  assign w_clear   = w_cmd_acc | w_last;

  mem_c_lane_packer #(
    .DATA_W (DATA_W),
    .ELEM_W (ELEM_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_data      (in_data),
    .word_full   (w_word_full),
    .packed_word (w_packed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_elem_cnt <= '0;
      r_word_idx <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_pend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_base     <= cmd_base;
            r_len      <= cmd_len;
            r_elem_cnt <= '0;
            r_word_idx <= '0;
            r_state    <= (cmd_len == '0) ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            r_elem_cnt <= r_elem_cnt + LEN_W'(1);
            if (w_word_full || w_last) begin
              r_wr_pend  <= 1'b1;
              r_wr_addr  <= r_base + r_word_idx;
              r_wr_data  <= w_packed;
              r_word_idx <= r_word_idx + ADDR_W'(1);
            end
            if (w_last) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are held low while reset is high, so a write scheduled for the reset cycle never strobes.
  assign w_wr        = w_run & r_wr_pend;
  assign cmd_ready   = w_run & (r_state == ST_IDLE);
  assign in_ready    = w_run & (r_state == ST_FILL);
  assign busy        = w_run & (r_state != ST_IDLE);
  assign done        = w_run & (r_state == ST_DONE);
  assign address2    = w_run ? r_wr_addr : '0;
  assign writedata2  = w_run ? r_wr_data : '0;
  assign chipselect2 = w_wr;
  assign write2      = w_wr;
  assign byteenable2 = {(DATA_W/8){w_wr}};
  assign clken2      = w_run;

`ifdef MEM_C_WRITER_PERF_EN
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles <= '0;
    end else if (w_cmd_acc) begin
      r_perf_cycles <= '0;
    end else if (r_state != ST_IDLE) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_mem_c_stream_writer.sv
// Scoreboard bench for mem_c_stream_writer: stimulus queues expected writes/done pulses, a monitor checks them.
module tb_mem_c_stream_writer;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [10:0]   cmd_base;
  logic [14:0]   cmd_len;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          busy;
  logic          done;
  logic [10:0]   address2;
  logic          chipselect2;
  logic          write2;
  logic [255:0]  writedata2;
  logic [31:0]   byteenable2;
  logic          clken2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [10:0]  addr;
    logic [255:0] data;
    int           cyc;
  } wr_t;

  wr_t          wq[$];
  int           dq[$];
  logic [10:0]  exp_addr [4];
  logic [255:0] exp_word [4];

  mem_c_stream_writer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .busy        (busy),
    .done        (done),
    .address2    (address2),
    .chipselect2 (chipselect2),
    .write2      (write2),
    .writedata2  (writedata2),
    .byteenable2 (byteenable2),
    .clken2      (clken2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic logic [255:0] word8(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  // Monitor: every strobe and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (write2 === 1'b1) begin
      if (wq.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 256'(address2), 256'(e.addr));
        chk("wr_data", writedata2, e.data);
        chk("wr_cycle", 256'(cyc), 256'(e.cyc));
        chk("wr_cs_be", {chipselect2, byteenable2}, {1'b1, 32'hFFFF_FFFF});
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        int d;
        d = dq.pop_front();
        chk("done_cycle", 256'(cyc), 256'(d));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [10:0] base, input logic [14:0] len, output int acc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    acc = cyc;
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic push_elem(input logic [31:0] d, output int acc, output logic rdy);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    acc = cyc;
    rdy = cmd_ready;
    sync();
    in_valid = 1'b0;
  endtask

  task automatic stream(input int len, input logic [31:0] v0, input bit bubble, input bit inject,
                        output int rdy_cyc);
    int   a;
    int   w = 0;
    logic r;
    wr_t  e;
    rdy_cyc = 0;
    for (int i = 0; i < len; i++) begin
      push_elem(v0 + 32'(i), a, r);
      if (inject && i == 2) begin
        cmd_valid = 1'b1;
        cmd_base  = 11'h100;
        cmd_len   = 15'd8;
      end
      if (inject && i > 2) chk("busy_cmd_ready", 256'(r), 256'(0));
      if ((i % 8) == 7 || i == len - 1) begin
        e.addr = exp_addr[w];
        e.data = exp_word[w];
        e.cyc  = a + 1;
        wq.push_back(e);
        w++;
      end
      if (i == len - 1) begin
        dq.push_back(a + 2);
        rdy_cyc = a + 3;
      end
      if (bubble) sync();
    end
  endtask

  task automatic check_ready(input int target);
    @(negedge clk);
    while (cyc < target - 1) @(negedge clk);
    chk("ready_early", 256'(cmd_ready), 256'(0));
    @(negedge clk);
    chk("ready_back", 256'(cmd_ready), 256'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int rc;
    logic r;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {cmd_ready, in_ready, busy, done, chipselect2, write2, clken2,
                          |address2, |writedata2, |byteenable2}, '0);
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {cmd_ready, busy, clken2}, {1'b1, 1'b0, 1'b1});

    // Aligned word
    sync();
    exp_addr[0] = 11'h010;
    exp_word[0] = word8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    send_cmd(11'h010, 15'd8, a);
    stream(8, 32'd1, 1'b0, 1'b0, rc);
    check_ready(rc);

    // Wrap and partial word
    sync();
    exp_addr[0] = 11'h7FF;
    exp_word[0] = word8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    exp_addr[1] = 11'h000;
    exp_word[1] = word8(32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16);
    exp_addr[2] = 11'h001;
    exp_word[2] = word8(32'd17, 32'd18, 32'd19, 32'd20, 32'd0, 32'd0, 32'd0, 32'd0);
    send_cmd(11'h7FF, 15'd20, a);
    stream(20, 32'd1, 1'b0, 1'b0, rc);
    check_ready(rc);

    // Zero length
    sync();
    send_cmd(11'h055, 15'd0, a);
    dq.push_back(a + 1);
    check_ready(a + 2);

    // Bubbles
    sync();
    exp_addr[0] = 11'h020;
    exp_word[0] = word8(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                        32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007);
    exp_addr[1] = 11'h021;
    exp_word[1] = word8(32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 32'h1000_000B,
                        32'h1000_000C, 32'h1000_000D, 32'h1000_000E, 32'h1000_000F);
    send_cmd(11'h020, 15'd16, a);
    stream(16, 32'h1000_0000, 1'b1, 1'b0, rc);
    check_ready(rc);

    // Reset mid-operation after 5 of 8 elements
    sync();
    send_cmd(11'h040, 15'd8, a);
    for (int i = 0; i < 5; i++) push_elem(32'hDEAD_0000 + 32'(i), a, r);
    reset = 1'b1;
    @(negedge clk);
    chk("outputs_in_reset", {cmd_ready, in_ready, busy, done, chipselect2, write2, clken2,
                             |address2, |writedata2, |byteenable2}, '0);
    sync();
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", {cmd_ready, busy}, {1'b1, 1'b0});

    // Command offered while busy
    sync();
    exp_addr[0] = 11'h080;
    exp_word[0] = word8(32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205, 32'h206, 32'h207);
    exp_addr[1] = 11'h081;
    exp_word[1] = word8(32'h208, 32'h209, 32'h20A, 32'h20B, 32'h20C, 32'h20D, 32'h20E, 32'h20F);
    send_cmd(11'h080, 15'd16, a);
    stream(16, 32'h200, 1'b0, 1'b1, rc);
    check_ready(rc);
    sync();
    cmd_valid = 1'b0;
    chk("held_cmd_accepted", 256'(busy), 256'(1));
    exp_addr[0] = 11'h100;
    exp_word[0] = word8(32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306, 32'h307);
    stream(8, 32'h300, 1'b0, 1'b0, rc);
    check_ready(rc);

    repeat (5) sync();
    chk("writes_outstanding", 256'(wq.size()), 256'(0));
    chk("dones_outstanding", 256'(dq.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
